// File: rtl/calc_sequencer.sv
// ============================================================================
// Module   : calc_sequencer
// Brief    : Instruction FIFO plus issue/write-back FSM for the calculator ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [4:0]      Instr,
    input  logic            InstrValid,
    output logic            InstrReady,
    output logic            Perform,
    output logic [2:0]      OP,
    output logic [1:0]      K,
    input  logic [4:0]      R0,
    input  logic [4:0]      R1,
    input  logic [4:0]      R2,
    input  logic [4:0]      R3,
    output logic [4:0]      a,
    output logic [4:0]      b,
    output logic [4:0]      c,
    output logic [4:0]      d,
    output logic            Done,
    output logic            Busy,
    output logic [CNTW-1:0] InstrCount
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      mem_q [DEPTH];
    logic [4:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     occ_q, occ_d;
    logic [2:0]      op_q, op_d;
    logic [1:0]      k_q, k_d;
    logic [4:0]      reg_q [4];
    logic [4:0]      reg_d [4];
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            full, empty, push, pop, bypass;
    logic [4:0]      head;
    logic [4:0]      r_in [4];

    always_comb begin
        full       = (occ_q == DEPTH[PW:0]);
        empty      = (occ_q == '0);
        InstrReady = Resetn && !full;
        push       = InstrValid && InstrReady;
        // An instruction arriving during WB into an empty FIFO is forwarded straight to issue.
        bypass     = empty && push && (state_q == S_WB);
        head       = bypass ? Instr : mem_q[rd_ptr_q];
        r_in[0]    = R0;
        r_in[1]    = R1;
        r_in[2]    = R2;
        r_in[3]    = R3;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        op_d    = op_q;
        k_d     = k_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WB;
                case (op_q)
                    3'b000: begin
                        reg_d[0] = R0;
                        reg_d[1] = R1;
                        reg_d[2] = R2;
                        reg_d[3] = R3;
                    end
                    3'b011:  reg_d[k_q] = r_in[k_q];
                    default: reg_d[0]   = R0;
                endcase
            end
            S_WB: begin
                cnt_d = cnt_q + CNTW'(1);
                if (!empty || push) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            {op_d, k_d} = head;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = Instr;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        occ_d = occ_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            op_q     <= '0;
            k_q      <= '0;
            reg_q    <= '{default: 5'd0};
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            op_q     <= op_d;
            k_q      <= k_d;
            reg_q    <= reg_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign Perform    = (state_q == S_ISSUE);
    assign Done       = (state_q == S_WB);
    assign Busy       = (occ_q != '0) || (state_q != S_IDLE);
    assign OP         = op_q;
    assign K          = k_q;
    assign a          = reg_q[0];
    assign b          = reg_q[1];
    assign c          = reg_q[2];
    assign d          = reg_q[3];
    assign InstrCount = cnt_q;

endmodule

`default_nettype wire
